dual_port_ram_be: RTL and testbench

Parametrised true dual-port synchronous RAM for caches and register-file style storage in the core.
- Per-byte write enables, per-port read enables, selectable read-during-write mode and optional output pipeline register.
- Deterministic byte-merge on same-address write collisions.
- Hardware clear sequencer zeroes every word after reset and reports readiness.

---
 rtl/dual_port_ram_be_if.sv | 35 +++
 rtl/dual_port_ram_be.sv | 157 +++++++++++++++
 tb/tb_dual_port_ram_be.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dual_port_ram_be_if.sv
// Bus bundle for dual_port_ram_be: two read/write ports, byte enables,
// read strobes, collision flag and the ready indication.
interface dual_port_ram_be_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    localparam int LANES = DATA_WIDTH / 8;

    logic                     ready;
    logic                     re0;
    logic                     re1;
    logic                     we0;
    logic                     we1;
    logic [LANES-1:0]         be0;
    logic [LANES-1:0]         be1;
    logic [ADDRESS_WIDTH-1:0] address0;
    logic [ADDRESS_WIDTH-1:0] address1;
    logic [DATA_WIDTH-1:0]    data_in0;
    logic [DATA_WIDTH-1:0]    data_in1;
    logic [DATA_WIDTH-1:0]    data_out0;
    logic [DATA_WIDTH-1:0]    data_out1;
    logic                     valid0;
    logic                     valid1;
    logic                     collision;

    modport master (
        input  ready, data_out0, data_out1, valid0, valid1, collision,
        output re0, re1, we0, we1, be0, be1, address0, address1, data_in0, data_in1
    );

    modport slave (
        output ready, data_out0, data_out1, valid0, valid1, collision,
        input  re0, re1, we0, we1, be0, be1, address0, address1, data_in0, data_in1
    );
endinterface

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with byte enables, deterministic same-index write merge,
// selectable read-during-write behaviour, optional output register and clear sweep.
module dual_port_ram_be #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int INDEX_BITS     = 6,
    parameter int READ_MODE      = 0,
    parameter int OUTPUT_REG     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    dual_port_ram_be_if.slave    bus
);
    localparam int LANES     = DATA_WIDTH / 8;
    localparam int RAM_DEPTH = 1 << INDEX_BITS;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                  state;
    logic [INDEX_BITS-1:0]   clear_count;
    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    logic [INDEX_BITS-1:0]   idx0;
    logic [INDEX_BITS-1:0]   idx1;
    logic                    active;
    logic                    same_index;
    logic [DATA_WIDTH-1:0]   old0;
    logic [DATA_WIDTH-1:0]   old1;
    logic [DATA_WIDTH-1:0]   new0;
    logic [DATA_WIDTH-1:0]   new1;
    logic [DATA_WIDTH-1:0]   rd0;
    logic [DATA_WIDTH-1:0]   rd1;

    logic                    collision_q;
    logic [DATA_WIDTH-1:0]   stage_data0;
    logic [DATA_WIDTH-1:0]   stage_data1;
    logic                    stage_valid0;
    logic                    stage_valid1;

    logic [ADDRESS_WIDTH-1:0] unused_addr;

    assign idx0        = bus.address0[INDEX_BITS-1:0];
    assign idx1        = bus.address1[INDEX_BITS-1:0];
    assign unused_addr = bus.address0 ^ bus.address1;
    assign active      = (state == READY);
    assign same_index  = (idx0 == idx1);

    // Post-write word seen at each index; port 1 lanes are applied last so they win.
    always_comb begin
        old0 = mem[idx0];
        old1 = mem[idx1];
        new0 = old0;
        new1 = old1;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (bus.we0 && bus.be0[i]) begin
                new0[8*i +: 8] = bus.data_in0[8*i +: 8];
                if (same_index) new1[8*i +: 8] = bus.data_in0[8*i +: 8];
            end
            if (bus.we1 && bus.be1[i]) begin
                new1[8*i +: 8] = bus.data_in1[8*i +: 8];
                if (same_index) new0[8*i +: 8] = bus.data_in1[8*i +: 8];
            end
        end
        rd0 = (READ_MODE != 0) ? old0 : new0;
        rd1 = (READ_MODE != 0) ? old1 : new1;
    end

    // Storage has no reset; writes are merely held off while reset is asserted.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (state == CLEAR) begin
                mem[clear_count] <= '0;
            end else begin
                if (bus.we0 && (|bus.be0)) mem[idx0] <= new0;
                if (bus.we1 && (|bus.be1)) mem[idx1] <= new1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clear_count  <= '0;
            collision_q  <= 1'b0;
            stage_data0  <= '0;
            stage_data1  <= '0;
            stage_valid0 <= 1'b0;
            stage_valid1 <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clear_count <= clear_count + 1'b1;
                    if (&clear_count) state <= READY;
                end
                READY: state <= READY;
                default: state <= CLEAR;
            endcase

            collision_q <= active && bus.we0 && bus.we1 && same_index;

            if (active && bus.re0) begin
                stage_data0  <= rd0;
                stage_valid0 <= 1'b1;
            end else begin
                stage_valid0 <= 1'b0;
            end

            if (active && bus.re1) begin
                stage_data1  <= rd1;
                stage_valid1 <= 1'b1;
            end else begin
                stage_valid1 <= 1'b0;
            end
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_data0;
            logic [DATA_WIDTH-1:0] out_data1;
            logic                  out_valid0;
            logic                  out_valid1;

            // Second stage only loads when a fresh valid word arrives.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    out_data0  <= '0;
                    out_data1  <= '0;
                    out_valid0 <= 1'b0;
                    out_valid1 <= 1'b0;
                end else begin
                    out_valid0 <= stage_valid0;
                    out_valid1 <= stage_valid1;
                    if (stage_valid0) out_data0 <= stage_data0;
                    if (stage_valid1) out_data1 <= stage_data1;
                end
            end

            assign bus.data_out0 = out_data0;
            assign bus.data_out1 = out_data1;
            assign bus.valid0    = out_valid0;
            assign bus.valid1    = out_valid1;
        end else begin : g_out_direct
            assign bus.data_out0 = stage_data0;
            assign bus.data_out1 = stage_data1;
            assign bus.valid0    = stage_valid0;
            assign bus.valid1    = stage_valid1;
        end
    endgenerate

    assign bus.ready     = active;
    assign bus.collision = collision_q;
endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: a write-first/no-output-register instance and a
// read-first/output-register instance share stimulus and are checked against a word-array model.
module tb_dual_port_ram_be;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int IB    = 4;
    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        re0, re1, we0, we1;
    logic [3:0]  be0, be1;
    logic [31:0] address0, address1, data_in0, data_in1;

    always #5 clock = ~clock;

    dual_port_ram_be_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus_a ();
    dual_port_ram_be_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus_b ();

    assign bus_a.re0 = re0;           assign bus_b.re0 = re0;
    assign bus_a.re1 = re1;           assign bus_b.re1 = re1;
    assign bus_a.we0 = we0;           assign bus_b.we0 = we0;
    assign bus_a.we1 = we1;           assign bus_b.we1 = we1;
    assign bus_a.be0 = be0;           assign bus_b.be0 = be0;
    assign bus_a.be1 = be1;           assign bus_b.be1 = be1;
    assign bus_a.address0 = address0; assign bus_b.address0 = address0;
    assign bus_a.address1 = address1; assign bus_b.address1 = address1;
    assign bus_a.data_in0 = data_in0; assign bus_b.data_in0 = data_in0;
    assign bus_a.data_in1 = data_in1; assign bus_b.data_in1 = data_in1;

    dual_port_ram_be #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .INDEX_BITS(IB),
        .READ_MODE(0), .OUTPUT_REG(0), .CLEAR_ON_RESET(1)
    ) dut_a (.clock(clock), .reset(reset), .bus(bus_a));

    dual_port_ram_be #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .INDEX_BITS(IB),
        .READ_MODE(1), .OUTPUT_REG(1), .CLEAR_ON_RESET(1)
    ) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

    int total = 0;
    int bad   = 0;

    // Reference model: word array plus expected outputs of both instances.
    logic [31:0] m_mem [DEPTH];
    bit          m_ready;
    int          clear_cnt;
    logic [31:0] ea_d0, ea_d1, eb_d0, eb_d1, pb_d0, pb_d1;
    bit          ea_v0, ea_v1, eb_v0, eb_v1, pb_v0, pb_v1, e_col;

    typedef struct {
        bit          we0, we1, re0, re1;
        logic [3:0]  be0, be1;
        logic [31:0] a0, a1, d0, d1;
        logic [31:0] a_do0, a_do1;
        bit          a_v0, a_v1, a_col;
        logic [31:0] b_do1;
        bit          b_v1;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ready   = 0;
        clear_cnt = 0;
        ea_d0 = '0; ea_d1 = '0; eb_d0 = '0; eb_d1 = '0; pb_d0 = '0; pb_d1 = '0;
        ea_v0 = 0;  ea_v1 = 0;  eb_v0 = 0;  eb_v1 = 0;  pb_v0 = 0;  pb_v1 = 0;
        e_col = 0;
    endtask

    task automatic model_edge();
        logic [31:0] old_mem [DEPTH];
        int i0, i1;
        if (reset !== 1'b1) return;
        eb_v0 = pb_v0; if (pb_v0) eb_d0 = pb_d0;
        eb_v1 = pb_v1; if (pb_v1) eb_d1 = pb_d1;
        pb_v0 = 0; pb_v1 = 0; ea_v0 = 0; ea_v1 = 0; e_col = 0;
        if (!m_ready) begin
            clear_cnt++;
            if (clear_cnt == DEPTH) begin
                m_ready = 1;
                foreach (m_mem[k]) m_mem[k] = '0;
            end
            return;
        end
        i0 = int'(address0 % DEPTH);
        i1 = int'(address1 % DEPTH);
        old_mem = m_mem;
        for (int l = 0; l < 4; l++) begin
            if (we0 && be0[l]) m_mem[i0][8*l +: 8] = data_in0[8*l +: 8];
        end
        for (int l = 0; l < 4; l++) begin
            if (we1 && be1[l]) m_mem[i1][8*l +: 8] = data_in1[8*l +: 8];
        end
        e_col = we0 && we1 && (i0 == i1);
        if (re0) begin ea_v0 = 1; ea_d0 = m_mem[i0]; pb_v0 = 1; pb_d0 = old_mem[i0]; end
        if (re1) begin ea_v1 = 1; ea_d1 = m_mem[i1]; pb_v1 = 1; pb_d1 = old_mem[i1]; end
    endtask

    task automatic check_outputs();
        chk("a_ready", bus_a.ready, m_ready);
        chk("b_ready", bus_b.ready, m_ready);
        chk("a_data_out0", bus_a.data_out0, ea_d0);
        chk("a_data_out1", bus_a.data_out1, ea_d1);
        chk("a_valid0", bus_a.valid0, ea_v0);
        chk("a_valid1", bus_a.valid1, ea_v1);
        chk("a_collision", bus_a.collision, e_col);
        chk("b_data_out0", bus_b.data_out0, eb_d0);
        chk("b_data_out1", bus_b.data_out1, eb_d1);
        chk("b_valid0", bus_b.valid0, eb_v0);
        chk("b_valid1", bus_b.valid1, eb_v1);
        chk("b_collision", bus_b.collision, e_col);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic set_idle();
        re0 = 0; re1 = 0; we0 = 0; we1 = 0; be0 = '0; be1 = '0;
        address0 = '0; address1 = '0; data_in0 = '0; data_in1 = '0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (bus_a.ready !== 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        chk(name, n, 16);
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < DEPTH; i++) begin
            re0 = 1; re1 = 1;
            address0 = i; address1 = DEPTH - 1 - i;
            cycle();
            chk("cleared_word", bus_a.data_out0, 32'h0);
            chk("cleared_valid", bus_a.valid0, 1'b1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{0,0,0,0, 4'h0,4'h0, 32'h0,32'h0, 32'h0,32'h0, 32'h0,32'h0, 0,0,0, 32'h0,1};
        vecs[1]  = '{1,0,0,0, 4'hF,4'h0, 32'h3,32'h0, 32'hDEADBEEF,32'h0, 32'h0,32'h0, 0,0,0, 32'h0,0};
        vecs[2]  = '{0,1,0,0, 4'h0,4'h5, 32'h0,32'h3, 32'h0,32'h11223344, 32'h0,32'h0, 0,0,0, 32'h0,0};
        vecs[3]  = '{0,0,0,1, 4'h0,4'h0, 32'h0,32'hFFFFFFF3, 32'h0,32'h0, 32'h0,32'hDE22BE44, 0,1,0, 32'h0,0};
        vecs[4]  = '{0,0,0,0, 4'h0,4'h0, 32'h0,32'h0, 32'h0,32'h0, 32'h0,32'hDE22BE44, 0,0,0, 32'hDE22BE44,1};
        vecs[5]  = '{1,1,0,0, 4'hF,4'h3, 32'h5,32'h5, 32'hAAAAAAAA,32'h55555555, 32'h0,32'hDE22BE44, 0,0,1, 32'hDE22BE44,0};
        vecs[6]  = '{0,0,1,0, 4'h0,4'h0, 32'h5,32'h0, 32'h0,32'h0, 32'hAAAA5555,32'hDE22BE44, 1,0,0, 32'hDE22BE44,0};
        vecs[7]  = '{1,0,0,0, 4'h1,4'h0, 32'h7,32'h0, 32'h0000000F,32'h0, 32'hAAAA5555,32'hDE22BE44, 0,0,0, 32'hDE22BE44,0};
        vecs[8]  = '{1,0,0,1, 4'hF,4'h0, 32'h7,32'h7, 32'h12345678,32'h0, 32'hAAAA5555,32'h12345678, 0,1,0, 32'hDE22BE44,0};
        vecs[9]  = '{0,0,0,0, 4'h0,4'h0, 32'h0,32'h0, 32'h0,32'h0, 32'hAAAA5555,32'h12345678, 0,0,0, 32'h0000000F,1};
        vecs[10] = '{1,0,0,0, 4'hF,4'h0, 32'h2,32'h0, 32'h00000001,32'h0, 32'hAAAA5555,32'h12345678, 0,0,0, 32'h0000000F,0};
        vecs[11] = '{0,0,1,0, 4'h0,4'h0, 32'h80000012,32'h0, 32'h0,32'h0, 32'h00000001,32'h12345678, 1,0,0, 32'h0000000F,0};
        for (int r = 12; r <= 14; r++)
            vecs[r] = '{1,0,0,0, 4'hF,4'h0, 32'h2,32'h0, 32'h00000099,32'h0, 32'h00000001,32'h12345678, 0,0,0, 32'h0000000F,0};
        vecs[15] = '{0,0,1,0, 4'h0,4'h0, 32'h00000102,32'h0, 32'h0,32'h0, 32'h00000099,32'h12345678, 1,0,0, 32'h0000000F,0};

        set_idle();
        model_reset();
        foreach (m_mem[k]) m_mem[k] = '0;
        repeat (2) @(posedge clock);
        #1;
        check_outputs();

        // Sweep interrupted at clear counter 9, then a full sweep must follow.
        reset = 1'b1;
        repeat (9) cycle();
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        cycle();
        reset = 1'b1;
        wait_ready("clear_cycles_after_restart");
        read_all_zero();

        // Directed vectors: write/merge, collision, read-during-write, read hold.
        for (int v = 0; v < 16; v++) begin
            we0 = vecs[v].we0; we1 = vecs[v].we1; re0 = vecs[v].re0; re1 = vecs[v].re1;
            be0 = vecs[v].be0; be1 = vecs[v].be1;
            address0 = vecs[v].a0; address1 = vecs[v].a1;
            data_in0 = vecs[v].d0; data_in1 = vecs[v].d1;
            cycle();
            chk($sformatf("vec%0d_a_do0", v), bus_a.data_out0, vecs[v].a_do0);
            chk($sformatf("vec%0d_a_do1", v), bus_a.data_out1, vecs[v].a_do1);
            chk($sformatf("vec%0d_a_v0", v), bus_a.valid0, vecs[v].a_v0);
            chk($sformatf("vec%0d_a_v1", v), bus_a.valid1, vecs[v].a_v1);
            chk($sformatf("vec%0d_a_col", v), bus_a.collision, vecs[v].a_col);
            chk($sformatf("vec%0d_b_do1", v), bus_b.data_out1, vecs[v].b_do1);
            chk($sformatf("vec%0d_b_v1", v), bus_b.valid1, vecs[v].b_v1);
        end

        // Random traffic over a narrow index range to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            re0 = $urandom_range(0, 1); re1 = $urandom_range(0, 1);
            we0 = $urandom_range(0, 1); we1 = $urandom_range(0, 1);
            be0 = 4'($urandom); be1 = 4'($urandom);
            address0 = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 7));
            address1 = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 7));
            data_in0 = $urandom; data_in1 = $urandom;
            cycle();
        end

        // Asynchronous reset from a busy state, then the sweep must erase random data.
        set_idle();
        reset = 1'b0;
        #2;
        model_reset();
        check_outputs();
        reset = 1'b1;
        wait_ready("clear_cycles_after_traffic");
        read_all_zero();
        set_idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
